// File: rtl/sd_host_regfile_ctrl.sv
// sd_host_regfile_ctrl: SD host register file with sticky W1C status, irq, inhibit tracking and self-clearing soft reset
module sd_host_regfile_ctrl #(
   parameter int          DATA_W      = 128,
   parameter int          ADDR_W      = 5,
   parameter int          BLK_W       = 12,
   parameter int          RESP_W      = 128,
   parameter int          SRST_CYCLES = 8,
   parameter logic [15:0] HC_VERSION  = 16'h0002
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic              reg_write_en,
   input  logic              reg_read_en,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              data_valid_o,
   input  logic              command_complete,
   input  logic [RESP_W-1:0] response_i,
   input  logic [15:0]       normal_event_i,
   input  logic [15:0]       error_event_i,
   output logic              cmd_start,
   output logic [BLK_W-1:0]  block_size,
   output logic [15:0]       block_count,
   output logic [31:0]       argument,
   output logic [15:0]       transfer_mode,
   output logic [15:0]       command,
   output logic [15:0]       timeout_control,
   output logic [2:0]        software_reset,
   output logic [15:0]       present_state,
   output logic              irq
);
   localparam int CNT_W = $clog2(SRST_CYCLES + 1);
   localparam logic [ADDR_W-1:0] A_BLK   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_CNT   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_ARG   = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_XFER  = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_CMD   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_RESP  = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_PST   = ADDR_W'(6);
   localparam logic [ADDR_W-1:0] A_TMO   = ADDR_W'(7);
   localparam logic [ADDR_W-1:0] A_SRST  = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] A_NIS   = ADDR_W'(9);
   localparam logic [ADDR_W-1:0] A_EIS   = ADDR_W'(10);
   localparam logic [ADDR_W-1:0] A_NISE  = ADDR_W'(11);
   localparam logic [ADDR_W-1:0] A_EISE  = ADDR_W'(12);
   localparam logic [ADDR_W-1:0] A_NISGE = ADDR_W'(13);
   localparam logic [ADDR_W-1:0] A_EISGE = ADDR_W'(14);
   localparam logic [ADDR_W-1:0] A_HCV   = ADDR_W'(15);

   logic              wr, rd, cmd_accept, cmd_inhibit, dat_inhibit, unused;
   logic [RESP_W-1:0] response;
   logic [14:0]       nis, nis_set, nis_clr;
   logic [15:0]       nis_full, eis, eis_set, eis_clr, ev_n;
   logic [15:0]       nise, eise, nisge, eisge;
   logic [CNT_W-1:0]  srst_cnt;
   logic [DATA_W-1:0] rdata;

   // host writes are frozen while the full soft reset is active; a write always wins over a read
   assign wr         = reg_write_en & ~software_reset[0];
   assign rd         = reg_read_en & ~reg_write_en;
   assign cmd_accept = wr && adr_i == A_CMD && !cmd_inhibit;
   assign ev_n       = normal_event_i | {15'd0, command_complete};
   assign nis_set    = ev_n[14:0] & nise[14:0];
   assign nis_clr    = (wr && adr_i == A_NIS) ? data_i[14:0] : '0;
   assign eis_set    = error_event_i & eise;
   assign eis_clr    = (wr && adr_i == A_EIS) ? data_i[15:0] : '0;
   assign nis_full   = {|eis, nis};
   assign present_state = {14'd0, dat_inhibit, cmd_inhibit};
   assign irq        = |(nis_full & nisge) | |(eis & eisge);
   assign unused     = ^{data_i, normal_event_i[15], nise[15]};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         software_reset <= '0;
         srst_cnt       <= '0;
      end else if (wr && adr_i == A_SRST && software_reset == 3'd0) begin
         software_reset <= data_i[2:0];
         srst_cnt       <= CNT_W'(SRST_CYCLES);
      end else if (srst_cnt != '0) begin
         srst_cnt       <= srst_cnt - 1'b1;
         software_reset <= (srst_cnt == CNT_W'(1)) ? 3'd0 : software_reset;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset || software_reset[0]) begin
         block_size      <= '0;
         block_count     <= '0;
         argument        <= '0;
         transfer_mode   <= '0;
         command         <= '0;
         timeout_control <= '0;
         response        <= '0;
         cmd_inhibit     <= 1'b0;
         dat_inhibit     <= 1'b0;
         cmd_start       <= 1'b0;
         nis             <= '0;
         eis             <= '0;
         nise            <= '0;
         eise            <= '0;
         nisge           <= '0;
         eisge           <= '0;
      end else begin
         cmd_start       <= cmd_accept;
         block_size      <= (wr && adr_i == A_BLK)   ? data_i[BLK_W-1:0] : block_size;
         block_count     <= (wr && adr_i == A_CNT)   ? data_i[15:0]      : block_count;
         argument        <= (wr && adr_i == A_ARG)   ? data_i[31:0]      : argument;
         transfer_mode   <= (wr && adr_i == A_XFER)  ? data_i[15:0]      : transfer_mode;
         command         <= cmd_accept               ? data_i[15:0]      : command;
         timeout_control <= (wr && adr_i == A_TMO)   ? data_i[15:0]      : timeout_control;
         nise            <= (wr && adr_i == A_NISE)  ? data_i[15:0]      : nise;
         eise            <= (wr && adr_i == A_EISE)  ? data_i[15:0]      : eise;
         nisge           <= (wr && adr_i == A_NISGE) ? data_i[15:0]      : nisge;
         eisge           <= (wr && adr_i == A_EISGE) ? data_i[15:0]      : eisge;
         response        <= software_reset[1] ? '0 : command_complete ? response_i : response;
         cmd_inhibit     <= software_reset[1] ? 1'b0 : cmd_accept ? 1'b1 : command_complete ? 1'b0 : cmd_inhibit;
         dat_inhibit     <= software_reset[2] ? 1'b0 : (cmd_accept && data_i[5]) ? 1'b1 :
                            normal_event_i[1] ? 1'b0 : dat_inhibit;
         // sets beat same-cycle clears; line resets wipe their done bits
         nis             <= ((nis & ~nis_clr) | nis_set) & ~{13'd0, software_reset[2], software_reset[1]};
         eis             <= (eis & ~eis_clr) | eis_set;
      end
   end

   always_comb begin
      rdata = '0;
      case (adr_i)
         A_BLK:   rdata[BLK_W-1:0]  = block_size;
         A_CNT:   rdata[15:0]       = block_count;
         A_ARG:   rdata[31:0]       = argument;
         A_XFER:  rdata[15:0]       = transfer_mode;
         A_CMD:   rdata[15:0]       = command;
         A_RESP:  rdata[RESP_W-1:0] = response;
         A_PST:   rdata[15:0]       = present_state;
         A_TMO:   rdata[15:0]       = timeout_control;
         A_SRST:  rdata[2:0]        = software_reset;
         A_NIS:   rdata[15:0]       = nis_full;
         A_EIS:   rdata[15:0]       = eis;
         A_NISE:  rdata[15:0]       = nise;
         A_EISE:  rdata[15:0]       = eise;
         A_NISGE: rdata[15:0]       = nisge;
         A_EISGE: rdata[15:0]       = eisge;
         A_HCV:   rdata[15:0]       = HC_VERSION;
         default: rdata             = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_o       <= '0;
         data_valid_o <= 1'b0;
      end else begin
         data_valid_o <= rd;
         data_o       <= rd ? rdata : data_o;
      end
   end
endmodule

// File: tb/tb_sd_host_regfile_ctrl.sv
// tb_sd_host_regfile_ctrl: directed table, soft/async reset sequences and random traffic against a register-map model
module tb_sd_host_regfile_ctrl;
   logic         clock, reset;
   logic [4:0]   adr;
   logic         we, re, cc;
   logic [31:0]  wd;
   logic [95:0]  wd_hi;
   logic [127:0] resp;
   logic [15:0]  nev, eev;
   logic [127:0] data_o;
   logic         data_valid_o, cmd_start, irq;
   logic [11:0]  block_size;
   logic [15:0]  block_count, transfer_mode, command, timeout_control, present_state;
   logic [31:0]  argument;
   logic [2:0]   software_reset;

   int n_vec = 0, n_miss = 0;

   sd_host_regfile_ctrl dut (
      .clock(clock), .reset(reset), .adr_i(adr), .reg_write_en(we), .reg_read_en(re),
      .data_i({wd_hi, wd}), .data_o(data_o), .data_valid_o(data_valid_o),
      .command_complete(cc), .response_i(resp), .normal_event_i(nev), .error_event_i(eev),
      .cmd_start(cmd_start), .block_size(block_size), .block_count(block_count),
      .argument(argument), .transfer_mode(transfer_mode), .command(command),
      .timeout_control(timeout_control), .software_reset(software_reset),
      .present_state(present_state), .irq(irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // model: registers kept as an address-indexed array
   logic [31:0]  m_reg [16];
   logic [127:0] m_resp, m_data;
   logic         m_cinh, m_dinh, m_valid, m_start;
   logic [15:0]  m_nis, m_eis;
   logic [2:0]   m_sr;
   int           m_left;

   task automatic model_reset();
      foreach (m_reg[i]) m_reg[i] = '0;
      m_resp = '0; m_data = '0; m_cinh = 0; m_dinh = 0; m_valid = 0; m_start = 0;
      m_nis = '0; m_eis = '0; m_sr = '0; m_left = 0;
   endtask

   function automatic logic [127:0] m_read(int a);
      case (a)
         0, 1, 2, 3, 4, 7, 11, 12, 13, 14: return {96'd0, m_reg[a]};
         5:  return m_resp;
         6:  return {126'd0, m_dinh, m_cinh};
         8:  return {125'd0, m_sr};
         9:  return {112'd0, |m_eis, m_nis[14:0]};
         10: return {112'd0, m_eis};
         15: return 128'h2;
         default: return '0;
      endcase
   endfunction

   function automatic logic m_irq();
      return |({|m_eis, m_nis[14:0]} & m_reg[13][15:0]) | |(m_eis & m_reg[14][15:0]);
   endfunction

   task automatic model_step();
      logic host, acc;
      logic [2:0] sr0;
      int a;
      a = int'(adr);
      sr0 = m_sr;
      host = we && !sr0[0];
      m_valid = re && !we;
      if (m_valid) m_data = m_read(a);
      if (host && a == 8 && sr0 == 3'd0) begin
         m_sr = wd[2:0];
         m_left = 8;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) m_sr = '0;
      end
      if (sr0[0]) begin
         foreach (m_reg[i]) m_reg[i] = '0;
         m_resp = '0; m_cinh = 0; m_dinh = 0; m_nis = '0; m_eis = '0; m_start = 0;
      end else begin
         acc = host && a == 4 && !m_cinh;
         m_nis = ((m_nis & ~((host && a == 9) ? wd[15:0] : 16'h0)) | ((nev | {15'd0, cc}) & m_reg[11][15:0])) & 16'h7fff;
         m_eis = (m_eis & ~((host && a == 10) ? wd[15:0] : 16'h0)) | (eev & m_reg[12][15:0]);
         m_start = acc;
         m_cinh = acc ? 1'b1 : cc ? 1'b0 : m_cinh;
         m_dinh = (acc && wd[5]) ? 1'b1 : nev[1] ? 1'b0 : m_dinh;
         if (cc) m_resp = resp;
         if (acc) m_reg[4] = {16'd0, wd[15:0]};
         if (host && a inside {0, 1, 2, 3, 7, 11, 12, 13, 14})
            m_reg[a] = wd & (a == 0 ? 32'hfff : a == 2 ? 32'hffffffff : 32'hffff);
         if (sr0[1]) begin m_cinh = 0; m_resp = '0; m_nis[0] = 0; end
         if (sr0[2]) begin m_dinh = 0; m_nis[1] = 0; end
      end
   endtask

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("data_o", data_o, m_data);
      chk("data_valid_o", data_valid_o, m_valid);
      chk("cmd_start", cmd_start, m_start);
      chk("irq", irq, m_irq());
      chk("present_state", present_state, {14'd0, m_dinh, m_cinh});
      chk("software_reset", software_reset, m_sr);
      chk("block_size", block_size, m_reg[0][11:0]);
      chk("block_count", block_count, m_reg[1][15:0]);
      chk("argument", argument, m_reg[2]);
      chk("transfer_mode", transfer_mode, m_reg[3][15:0]);
      chk("command", command, m_reg[4][15:0]);
      chk("timeout_control", timeout_control, m_reg[7][15:0]);
   endtask

   task automatic idle();
      we = 0; re = 0; adr = '0; wd = '0; wd_hi = '0; cc = 0; resp = '0; nev = '0; eev = '0;
   endtask

   task automatic cycle();
      @(posedge clock);
      if (reset) model_step();
      #1;
      check_all();
   endtask

   task automatic arst();
      #3 reset = 1'b0;
      #1;
      model_reset();
      chk("arst_cmd_start", cmd_start, 1'b0);
      chk("arst_valid", data_valid_o, 1'b0);
      chk("arst_srst", software_reset, 3'd0);
      check_all();
      idle();
      @(posedge clock);
      #1 reset = 1'b1;
   endtask

   typedef struct {
      logic        we, re, cc;
      logic [4:0]  adr;
      logic [31:0] wd;
      logic [15:0] resp, nev, eev;
      logic        ev, es, eirq;
      logic [31:0] ed;
      logic [1:0]  eps;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t v(logic w, logic r, logic [4:0] a, logic [31:0] d, logic c,
                              logic [15:0] rs, logic [15:0] ne, logic [15:0] ee,
                              logic xv, logic [31:0] xd, logic xs, logic [1:0] xp, logic xi);
      vec_t t;
      t.we = w; t.re = r; t.adr = a; t.wd = d; t.cc = c; t.resp = rs; t.nev = ne; t.eev = ee;
      t.ev = xv; t.ed = xd; t.es = xs; t.eps = xp; t.eirq = xi;
      return t;
   endfunction

   initial begin
      tbl.push_back(v(1, 0,  2, 32'hDEADBEEF, 0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(0, 1,  2, 0,            0, 0,       0, 0,   1, 32'hDEADBEEF, 0, 0, 0));
      tbl.push_back(v(1, 0,  4, 32'h0020,     0, 0,       0, 0,   0, 0,            1, 3, 0));
      tbl.push_back(v(1, 0,  4, 32'h0020,     0, 0,       0, 0,   0, 0,            0, 3, 0));
      tbl.push_back(v(0, 1,  6, 0,            0, 0,       0, 0,   1, 3,            0, 3, 0));
      tbl.push_back(v(0, 0,  0, 0,            1, 16'h1234, 0, 0,  0, 0,            0, 2, 0));
      tbl.push_back(v(0, 1,  5, 0,            0, 0,       0, 0,   1, 32'h1234,     0, 2, 0));
      tbl.push_back(v(0, 0,  0, 0,            0, 0,       2, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(1, 0, 11, 1,            0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(1, 0, 13, 1,            0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(0, 0,  0, 0,            1, 0,       0, 0,   0, 0,            0, 0, 1));
      tbl.push_back(v(0, 1,  9, 0,            0, 0,       0, 0,   1, 1,            0, 0, 1));
      tbl.push_back(v(1, 0,  9, 1,            0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(1, 0, 11, 0,            0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(0, 0,  0, 0,            1, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(0, 1,  9, 0,            0, 0,       0, 0,   1, 0,            0, 0, 0));
      tbl.push_back(v(1, 0, 12, 4,            0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(1, 0, 14, 4,            0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(0, 0,  0, 0,            0, 0,       0, 4,   0, 0,            0, 0, 1));
      tbl.push_back(v(0, 1, 10, 0,            0, 0,       0, 0,   1, 4,            0, 0, 1));
      tbl.push_back(v(0, 1,  9, 0,            0, 0,       0, 0,   1, 32'h8000,     0, 0, 1));
      tbl.push_back(v(1, 0, 10, 4,            0, 0,       0, 4,   0, 0,            0, 0, 1));
      tbl.push_back(v(0, 1, 10, 0,            0, 0,       0, 0,   1, 4,            0, 0, 1));
      tbl.push_back(v(1, 0, 10, 4,            0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(1, 1,  7, 32'h55,       0, 0,       0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(0, 1,  7, 0,            0, 0,       0, 0,   1, 32'h55,       0, 0, 0));
      tbl.push_back(v(0, 1, 20, 0,            0, 0,       0, 0,   1, 0,            0, 0, 0));
      tbl.push_back(v(0, 1, 15, 0,            0, 0,       0, 0,   1, 2,            0, 0, 0));
      tbl.push_back(v(1, 0,  4, 0,            0, 0,       0, 0,   0, 0,            1, 1, 0));
      tbl.push_back(v(1, 0,  4, 32'hFF,       1, 16'h77,  0, 0,   0, 0,            0, 0, 0));
      tbl.push_back(v(0, 1,  4, 0,            0, 0,       0, 0,   1, 0,            0, 0, 0));
      tbl.push_back(v(0, 1,  5, 0,            0, 0,       0, 0,   1, 32'h77,       0, 0, 0));

      reset = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_all();
      reset = 1'b1;

      foreach (tbl[i]) begin
         we = tbl[i].we; re = tbl[i].re; adr = tbl[i].adr; wd = tbl[i].wd; cc = tbl[i].cc;
         resp = {112'd0, tbl[i].resp}; nev = tbl[i].nev; eev = tbl[i].eev;
         cycle();
         chk($sformatf("tbl%0d_valid", i), data_valid_o, tbl[i].ev);
         chk($sformatf("tbl%0d_start", i), cmd_start, tbl[i].es);
         chk($sformatf("tbl%0d_pstate", i), present_state, {14'd0, tbl[i].eps});
         chk($sformatf("tbl%0d_irq", i), irq, tbl[i].eirq);
         if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), data_o, {96'd0, tbl[i].ed});
      end

      idle();
      we = 1; adr = 8; wd = 1;
      cycle();
      chk("srst_set", software_reset, 3'b001);
      chk("srst_arg_kept", argument, 32'hDEADBEEF);
      for (int k = 1; k < 8; k++) begin
         we = 1; adr = 2; wd = k;
         cycle();
         chk("srst_hold", software_reset, 3'b001);
         chk("srst_arg_clear", argument, 32'd0);
      end
      idle();
      cycle();
      chk("srst_done", software_reset, 3'b000);
      re = 1; adr = 2;
      cycle();
      chk("srst_rd_arg", data_o, 128'd0);
      chk("srst_rd_valid", data_valid_o, 1'b1);
      adr = 7;
      cycle();
      chk("srst_rd_tmo", data_o, 128'd0);

      idle();
      we = 1; adr = 8; wd = 4;
      cycle();
      we = 1; adr = 4; wd = 32'h21;
      cycle();
      chk("pre_arst_start", cmd_start, 1'b1);
      idle();
      arst();
      re = 1; adr = 15;
      cycle();
      chk("pre_arst_valid", data_valid_o, 1'b1);
      idle();
      arst();

      for (int n = 0; n < 600; n++) begin
         we = ($urandom_range(3) == 0);
         re = ($urandom_range(2) == 0);
         adr = 5'($urandom_range(17));
         if (adr == 5'd8 && $urandom_range(3) != 0) adr = 5'd2;
         wd = $urandom;
         wd_hi = {$urandom, $urandom, $urandom};
         cc = ($urandom_range(9) == 0);
         resp = {$urandom, $urandom, $urandom, $urandom};
         nev = ($urandom_range(7) == 0) ? 16'($urandom) : 16'd0;
         eev = ($urandom_range(7) == 0) ? 16'($urandom) : 16'd0;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
